// File: rtl/reg_file_bank.sv
// rtl/reg_file_bank.sv - integer register file, 2 async read ports, 1 falling-edge write port
//
// NUM_REGS x DATA_W register file. Register 0 is hardwired to zero and has no storage.
// The write address is decoded into one-hot per-register enables. Each read port is a
// plain mux over the stored words.
//
// Optional build macro: REG_FILE_BYPASS_EN
//   When defined, each read port forwards wr_data during a matching write cycle.
//
// Ports:
//   clk        in   clock; registers update on the falling edge
//   reset      in   asynchronous, active-high; clears all registers and forces reads to 0
//   wr_en      in   write request for the current cycle
//   wr_addr    in   destination register
//   wr_data    in   data to write
//   rd_addr_a  in   read port A address
//   rd_addr_b  in   read port B address
//   rd_data_a  out  read port A data (combinational)
//   rd_data_b  out  read port B data (combinational)
module reg_file_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  // Storage exists only for registers 1..NUM_REGS-1.
  logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] wr_sel;

  // One-hot write enable decode. Address 0 has no enable, so writes to it vanish.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wr_sel[i] = wr_en && (wr_addr == ADDR_W'(i));
    end
  end

  // The asynchronous reset branch takes priority, so writes are ignored while reset is high.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  // Read muxes. Address 0 matches no loop term and falls through to the zero default.
  // Reads are also gated by reset, so data is 0 during reset regardless of stored state.
  logic [DATA_W-1:0] mux_a;
  logic [DATA_W-1:0] mux_b;

  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_addr_a == ADDR_W'(i)) begin
        mux_a = regs_q[i];
      end
      if (rd_addr_b == ADDR_W'(i)) begin
        mux_b = regs_q[i];
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Full-cycle forwarding. Each port independently sees the in-flight write data.
  logic byp_a;
  logic byp_b;

  always_comb begin
    byp_a = wr_en && (wr_addr == rd_addr_a) && (rd_addr_a != '0);
    byp_b = wr_en && (wr_addr == rd_addr_b) && (rd_addr_b != '0);
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!reset) begin
      rd_data_a = byp_a ? wr_data : mux_a;
      rd_data_b = byp_b ? wr_data : mux_b;
    end
  end
`else
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!reset) begin
      rd_data_a = mux_a;
      rd_data_b = mux_b;
    end
  end
`endif

endmodule
